// File: rtl/inv_mixcol_seq_if.sv
// Handshake bundle for inv_mixcol_seq: input/output streams, flush and status.
// The mode bit exists only when IMC_FWD_EN is defined.
interface inv_mixcol_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         flush;
  logic         busy;
`ifdef IMC_FWD_EN
  logic         mode;
`endif

  modport master (
    output in_valid, in_data, out_ready, flush,
`ifdef IMC_FWD_EN
    output mode,
`endif
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
`ifdef IMC_FWD_EN
    input  mode,
`endif
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_mixcol_seq.sv
// Sequential AES InvMixColumns: one column per cycle, fixed 4-cycle latency.
// Optional macro IMC_FWD_EN adds a latched mode bit selecting forward MixColumns.

module imc_col (
  input  logic [31:0] col,
`ifdef IMC_FWD_EN
  input  logic        fwd,
`endif
  output logic [31:0] res
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction
  function automatic logic [7:0] m11(input logic [7:0] b);
    return xt(xt(xt(b)) ^ b) ^ b;
  endfunction
  function automatic logic [7:0] m13(input logic [7:0] b);
    return xt(xt(xt(b) ^ b)) ^ b;
  endfunction
  function automatic logic [7:0] m14(input logic [7:0] b);
    return xt(xt(xt(b) ^ b) ^ b);
  endfunction

  // a[k] is row k; row 0 sits at the MSB of the column word
  logic [7:0] a [4];
  always_comb begin
    for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
  end

  for (genvar i = 0; i < 4; i++) begin : g_row
    localparam int J1 = (i + 1) % 4;
    localparam int J2 = (i + 2) % 4;
    localparam int J3 = (i + 3) % 4;
    logic [7:0] inv_b;
    assign inv_b = m14(a[i]) ^ m11(a[J1]) ^ m13(a[J2]) ^ m9(a[J3]);
`ifdef IMC_FWD_EN
    logic [7:0] fwd_b;
    assign fwd_b = xt(a[i]) ^ xt(a[J1]) ^ a[J1] ^ a[J2] ^ a[J3];
    assign res[31-8*i -: 8] = fwd ? fwd_b : inv_b;
`else
    assign res[31-8*i -: 8] = inv_b;
`endif
  end
endmodule

module inv_mixcol_seq (
  input  logic             clk,
  input  logic             rst_n,
  inv_mixcol_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_n;
  logic [1:0]          col_cnt;
  // data[3] is column 0, so column c lives at data[~c]
  logic [3:0][31:0]    data;
  logic [31:0]         cur_col, new_col;
  logic                accept, step;
`ifdef IMC_FWD_EN
  logic                mode_q;
`endif

  assign cur_col = data[~col_cnt];

  imc_col u_col (
    .col (cur_col),
`ifdef IMC_FWD_EN
    .fwd (mode_q),
`endif
    .res (new_col)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    if (bus.flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          accept  = 1'b1;
          state_n = CALC;
        end
        CALC: begin
          step = 1'b1;
          if (col_cnt == 2'd3) state_n = DONE;
        end
        DONE: if (bus.out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      col_cnt <= 2'd0;
`ifdef IMC_FWD_EN
      mode_q  <= 1'b0;
`endif
    end else if (bus.flush) begin
      data    <= '0;
      col_cnt <= 2'd0;
    end else if (accept) begin
      data    <= bus.in_data;
      col_cnt <= 2'd0;
`ifdef IMC_FWD_EN
      mode_q  <= bus.mode;
`endif
    end else if (step) begin
      data[~col_cnt] <= new_col;
      col_cnt        <= col_cnt + 2'd1;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = data;
endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Randomized self-checking bench for inv_mixcol_seq against a GF(2^8) reference model.
module tb_inv_mixcol_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inv_mixcol_seq_if bus();
  inv_mixcol_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [7:0] a = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit fwd);
    logic [127:0] r;
    logic [7:0] a [4];
    logic [7:0] k0, k1, k2, k3;
    k0 = fwd ? 8'd2 : 8'd14; k1 = fwd ? 8'd3 : 8'd11;
    k2 = fwd ? 8'd1 : 8'd13; k3 = fwd ? 8'd1 : 8'd9;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-32*c-8*i -: 8];
      for (int i = 0; i < 4; i++)
        r[127-32*c-8*i -: 8] = gmul(k0, a[i]) ^ gmul(k1, a[(i+1)%4]) ^
                               gmul(k2, a[(i+2)%4]) ^ gmul(k3, a[(i+3)%4]);
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
`ifdef IMC_FWD_EN
    bus.mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got v=%b d=%h b=%b exp 0", bus.out_valid, bus.out_data, bus.busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_vector();
    int n;
    logic [127:0] v = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    send(v);
    wait_out(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL vector_latency got %0d exp 4", n); end
    checks++;
    if (bus.out_data !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
      errors++; $display("FAIL vector_data got %h exp db135345f20a225c01010101c6c6c6c6", bus.out_data);
    end
    consume();
  endtask

  task automatic test_random();
    int n;
    logic [127:0] v, e;
    for (int t = 0; t < 6; t++) begin
      v = rnd128();
      e = model(v, 1'b0);
      send(v);
      wait_out(n);
      checks++;
      if (n !== 4) begin errors++; $display("FAIL random_latency[%0d] got %0d exp 4", t, n); end
      checks++;
      if (bus.out_data !== e) begin errors++; $display("FAIL random_data[%0d] got %h exp %h", t, bus.out_data, e); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad = 0;
    logic [127:0] v = rnd128();
    logic [127:0] v2 = rnd128();
    logic [127:0] e = model(v, 1'b0);
    send(v);
    wait_out(n);
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = v2;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept got busy=%b exp 1", bus.busy); end
    wait_out(n);
    checks++;
    if (n !== 4 || bus.out_data !== model(v2, 1'b0)) begin
      errors++; $display("FAIL bp_next_data got n=%0d %h exp n=4 %h", n, bus.out_data, model(v2, 1'b0));
    end
    consume();
  endtask

  task automatic test_flush();
    int n;
    logic [127:0] v = {32'h4d7ebdf8, $urandom, $urandom, $urandom};
    logic [127:0] e = model(v, 1'b0);
    send(rnd128());
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0) begin
      errors++; $display("FAIL flush_state got b=%b v=%b r=%b d=%h exp 0 0 1 0", bus.busy, bus.out_valid, bus.in_ready, bus.out_data);
    end
    send(v);
    wait_out(n);
    checks++;
    if (n !== 4 || bus.out_data !== e) begin
      errors++; $display("FAIL flush_next got n=%0d %h exp n=4 %h", n, bus.out_data, e);
    end
    checks++;
    if (bus.out_data[127:120] !== 8'h2d) begin
      errors++; $display("FAIL flush_byte got %h exp 2d", bus.out_data[127:120]);
    end
    consume();
    // flush wins over accept in IDLE
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.in_data = rnd128();
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_vs_accept got busy=%b exp 0", bus.busy);
    end
  endtask

  task automatic test_reset_in_done();
    int n;
    int bad = 0;
    send(rnd128());
    wait_out(n);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      errors++; $display("FAIL rst_done_async got v=%b d=%h exp 0", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_done_stale got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] stim [3];
    int acc [3];
    int cyc = 0, idx = 0, oidx = 0, bad = 0;
    for (int k = 0; k < 3; k++) stim[k] = rnd128();
    bus.out_ready = 1'b1;
    @(negedge clk);
    while ((idx < 3 || oidx < 3) && cyc < 80) begin
      if (bus.out_valid) begin
        if (oidx >= 3 || bus.out_data !== model(stim[oidx], 1'b0)) begin
          bad++; $display("FAIL b2b_data[%0d] got %h", oidx, bus.out_data);
        end
        oidx++;
      end
      if (bus.in_ready) begin
        if (idx < 3) begin
          bus.in_valid = 1'b1; bus.in_data = stim[idx]; acc[idx] = cyc + 1; idx++;
        end else bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bad != 0 || oidx != 3) begin errors++; $display("FAIL b2b_outputs got %0d outputs %0d bad exp 3 0", oidx, bad); end
    checks++;
    if (idx != 3 || acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
      errors++; $display("FAIL b2b_spacing got %0d,%0d exp 6,6", acc[1] - acc[0], acc[2] - acc[1]);
    end
  endtask

`ifdef IMC_FWD_EN
  task automatic test_fwd();
    int n;
    logic [127:0] v = rnd128();
    bus.mode = 1'b1;
    send(128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
    bus.mode = 1'b0;
    wait_out(n);
    checks++;
    if (n !== 4 || bus.out_data !== 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8) begin
      errors++; $display("FAIL fwd_vector got n=%0d %h exp n=4 8e4da1bc9fdc589dd5d5d7d64d7ebdf8", n, bus.out_data);
    end
    consume();
    bus.mode = 1'b1;
    send(v);
    bus.mode = 1'b0;
    wait_out(n);
    checks++;
    if (bus.out_data !== model(v, 1'b1)) begin
      errors++; $display("FAIL fwd_random got %h exp %h", bus.out_data, model(v, 1'b1));
    end
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_vector();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_in_done();
    test_back_to_back();
`ifdef IMC_FWD_EN
    test_fwd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_mixcol_seq.md
INV_MIXCOL_SEQ -- requirements
Module: inv_mixcol_seq

Interface
REQ-001 Parameters: none; all widths are fixed at 128-bit state and 8-bit bytes.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 in_valid  input  1  in_data is valid.
REQ-005 in_ready  output  1  Block can accept a state.
REQ-006 in_data  input  128  AES state; column c = bits [127-32c -: 32], row-0 byte at MSB of each column.
REQ-007 out_valid  output  1  out_data holds a finished result.
REQ-008 out_ready  input  1  Consumer accepts out_data.
REQ-009 out_data  output  128  Transformed state, same byte layout as in_data.
REQ-010 flush  input  1  Synchronous abort.
REQ-011 busy  output  1  High in any state other than IDLE.

Function
REQ-012 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 in_ready SHALL equal (state==IDLE); an input is accepted when in_valid&in_ready, which latches in_data into the state register, clears col_cnt to 0 and moves the FSM to CALC.
REQ-014 CALC SHALL transform one column per cycle, column index = col_cnt (2 bits), and write the result back in place.
REQ-015 The per-column transform SHALL be r0=14a0^11a1^13a2^9a3, r1=9a0^14a1^11a2^13a3, r2=13a0^9a1^14a2^11a3, r3=11a0^13a1^9a2^14a3 over GF(2^8) with polynomial 0x11B, using constant-multiplier tables for x9, x11, x13 and x14.
REQ-016 After column 3, col_cnt SHALL wrap to 0 and the FSM SHALL move to DONE.
REQ-017 Latency SHALL be fixed: out_valid rises exactly 4 cycles after the accept edge.
REQ-018 In DONE, out_valid SHALL be 1 and out_data SHALL hold stable until out_ready is sampled high; the FSM then returns to IDLE on that same edge.
REQ-019 Inputs are not accepted in CALC or DONE, so there is no overlap; maximum throughput is one state per 6 cycles when out_ready is held high.
REQ-020 flush SHALL return the FSM to IDLE on the next edge from any state, drop out_valid and zero the state register, and it SHALL take priority over both accept and out handshake.
REQ-021 in_valid and flush asserted together in IDLE SHALL result in IDLE with nothing accepted.
REQ-022 out_data SHALL be driven directly from the state register and SHALL NOT depend combinationally on any input.

Reset
REQ-023 When rst_n=0, the block SHALL asynchronously force state=IDLE, col_cnt=0, state register=0, out_valid=0, out_data=0, busy=0 and in_ready=1 once released.
REQ-024 Reset asserted mid-CALC or mid-DONE SHALL discard the in-flight state with no output handshake.

Configuration
REQ-025 Macro IMC_FWD_EN defined: the block SHALL add an input port mode (1 bit), latched at accept; mode=1 SHALL apply forward MixColumns (r0=2a0^3a1^a2^a3, rotated per row) with identical timing, and mode=0 SHALL apply the inverse transform.
REQ-026 Macro IMC_FWD_EN undefined: there SHALL be no mode port and only the inverse transform SHALL be built.

Verification
REQ-027 Inverse vector: in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_data=db135345_f20a225c_01010101_c6c6c6c6, with out_valid 4 cycles after accept.
REQ-028 Back-pressure: out_ready held low 10 cycles -> out_valid and out_data stable and in_ready=0 throughout; accept next input the cycle after out_ready=1.
REQ-029 Flush at CALC column 2 -> next cycle state=IDLE, out_valid=0, in_ready=1; a new input 4d7ebdf8_... then completes correctly with no corruption (row0 of column 0 = 2d).
REQ-030 Reset pulse asserted in DONE -> out_valid=0 immediately (asynchronously), out_data=0; no stale result appears after release.
REQ-031 Back-to-back stream of 3 states with in_valid and out_ready tied high -> accept edges exactly 6 cycles apart, outputs in order, each matching a software model.
REQ-032 With IMC_FWD_EN, mode=1 and in_data=db135345_f20a225c_d4d4d4d5_2d26314c -> out_data=8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8.
